// File: rtl/packet_buffer_read_controller.sv
// packet_buffer_read_controller: round-robin whole-packet drain of lane FIFOs onto one egress stream.
module packet_buffer_read_controller #(
  parameter int NUM_LANES             = 4,
  parameter int LANE_SELECT_IDX_WIDTH = 2,
  parameter int MAX_PACKETS_PER_LANE  = 16
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             wr_pkt_commit_i,
  input  logic [LANE_SELECT_IDX_WIDTH-1:0] wr_pkt_lane_i,
  input  logic                             fifo_valid_i [NUM_LANES],
  input  logic                             fifo_last_i  [NUM_LANES],
  output logic                             fifo_ready_o [NUM_LANES],
  input  logic                             output_ready_i,
  output logic                             output_valid_o,
  output logic                             output_last_o,
  output logic [LANE_SELECT_IDX_WIDTH-1:0] lane_sel_o,
  output logic                             lane_sel_valid_o,
  output logic                             overflow_o
);
  localparam int IW = LANE_SELECT_IDX_WIDTH;
  localparam int CW = $clog2(MAX_PACKETS_PER_LANE + 1);
  localparam logic [CW-1:0] CMAX = CW'(MAX_PACKETS_PER_LANE);
  typedef enum logic {IDLE, STREAM} state_e;
  state_e        state_q, state_d;
  logic [IW-1:0] sel_q, sel_d, rr_q, rr_d, hit_idx, idx;
  logic [CW-1:0] count_q [NUM_LANES];
  logic [CW-1:0] count_d [NUM_LANES];
  logic          overflow_q, overflow_d, hit, last_hs, inc, dec;
  // Descending scan so the lane closest to the rr pointer is the last writer and wins.
  always_comb begin
    hit = 1'b0;
    hit_idx = '0;
    idx = '0;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      idx = IW'((int'(rr_q) + i) % NUM_LANES);
      if (count_q[idx] != '0) begin
        hit = 1'b1;
        hit_idx = idx;
      end
    end
  end
  always_comb begin
    state_d = state_q;
    sel_d = sel_q;
    rr_d = rr_q;
    output_valid_o = 1'b0;
    output_last_o = 1'b0;
    last_hs = 1'b0;
    for (int i = 0; i < NUM_LANES; i++)
      fifo_ready_o[i] = (state_q == STREAM) && int'(sel_q) == i && output_ready_i;
    if (state_q == IDLE) begin
      state_d = hit ? STREAM : IDLE;
      sel_d = hit ? hit_idx : sel_q;
    end else begin
      output_valid_o = fifo_valid_i[sel_q];
      output_last_o = fifo_valid_i[sel_q] & fifo_last_i[sel_q];
      last_hs = output_last_o & output_ready_i;
      state_d = last_hs ? IDLE : STREAM;
      rr_d = !last_hs ? rr_q : (int'(sel_q) == NUM_LANES - 1) ? '0 : sel_q + 1'b1;
    end
  end
  // A commit and a drain on the same lane cancel, so saturation only matters for a lone commit.
  always_comb begin
    overflow_d = overflow_q;
    inc = 1'b0;
    dec = 1'b0;
    for (int i = 0; i < NUM_LANES; i++) begin
      inc = wr_pkt_commit_i && int'(wr_pkt_lane_i) == i;
      dec = last_hs && int'(sel_q) == i;
      count_d[i] = (inc && !dec && count_q[i] != CMAX) ? count_q[i] + 1'b1 :
                   (dec && !inc) ? count_q[i] - 1'b1 : count_q[i];
      overflow_d = overflow_d | (inc && !dec && count_q[i] == CMAX);
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      sel_q <= '0;
      rr_q <= '0;
      overflow_q <= 1'b0;
      for (int i = 0; i < NUM_LANES; i++) count_q[i] <= '0;
    end else begin
      state_q <= state_d;
      sel_q <= sel_d;
      rr_q <= rr_d;
      overflow_q <= overflow_d;
      for (int i = 0; i < NUM_LANES; i++) count_q[i] <= count_d[i];
    end
  end
  assign lane_sel_o = sel_q;
  assign lane_sel_valid_o = (state_q == STREAM);
  assign overflow_o = overflow_q;
endmodule

// File: tb/tb_packet_buffer_read_controller.sv
// tb_packet_buffer_read_controller: directed checks of arbitration, pass-through, counting and reset.
module tb_packet_buffer_read_controller;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       commit = 1'b0;
  logic [1:0] lane = '0;
  logic       fv [4];
  logic       fl [4];
  logic       fr [4];
  logic       ordy = 1'b0;
  logic       ov, ol, selv, ovf;
  logic [1:0] sel;
  int         vecs = 0;
  int         errs = 0;

  packet_buffer_read_controller dut (
    .clk_i(clk), .rst_ni(rst_n), .wr_pkt_commit_i(commit), .wr_pkt_lane_i(lane),
    .fifo_valid_i(fv), .fifo_last_i(fl), .fifo_ready_o(fr), .output_ready_i(ordy),
    .output_valid_o(ov), .output_last_o(ol), .lane_sel_o(sel),
    .lane_sel_valid_o(selv), .overflow_o(ovf)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_fifo();
    for (int i = 0; i < 4; i++) begin
      fv[i] = 1'b0;
      fl[i] = 1'b0;
    end
  endtask

  task automatic test_reset();
    clear_fifo();
    #2;
    vecs++; if ({ov, ol, selv, ovf} !== 4'b0) begin errs++; $display("FAIL reset_out got %b want 0000", {ov, ol, selv, ovf}); end
    vecs++; if (sel !== 2'd0) begin errs++; $display("FAIL reset_sel got %0d want 0", sel); end
    tick(); tick();
    rst_n = 1'b1;
    tick();
    vecs++; if (selv !== 1'b0) begin errs++; $display("FAIL reset_idle got %b want 0", selv); end
  endtask

  task automatic test_single();
    commit = 1'b1; lane = 2'd2;
    tick();
    commit = 1'b0;
    vecs++; if (selv !== 1'b0) begin errs++; $display("FAIL single_arb got %b want 0", selv); end
    tick();
    vecs++; if ({selv, sel} !== 3'b110) begin errs++; $display("FAIL single_sel got %b want 110", {selv, sel}); end
    vecs++; if (dut.count_q[2] !== 5'd1) begin errs++; $display("FAIL single_cnt1 got %0d want 1", dut.count_q[2]); end
    ordy = 1'b1; fv[2] = 1'b1;
    for (int b = 0; b < 3; b++) begin
      fl[2] = (b == 2);
      #1;
      vecs++; if ({ov, ol, fr[2], fr[0], fr[1], fr[3]} !== {1'b1, b == 2, 1'b1, 3'b000})
        begin errs++; $display("FAIL single_beat%0d got %b want %b", b, {ov, ol, fr[2], fr[0], fr[1], fr[3]}, {1'b1, b == 2, 1'b1, 3'b000}); end
      tick();
    end
    clear_fifo(); ordy = 1'b0;
    vecs++; if (selv !== 1'b0) begin errs++; $display("FAIL single_done got %b want 0", selv); end
    vecs++; if (dut.count_q[2] !== 5'd0) begin errs++; $display("FAIL single_cnt0 got %0d want 0", dut.count_q[2]); end
  endtask

  task automatic test_round_robin();
    logic [1:0] order [6];
    order = '{2'd0, 2'd1, 2'd3, 2'd0, 2'd1, 2'd3};
    for (int i = 0; i < 6; i++) begin
      commit = 1'b1; lane = order[i];
      tick();
    end
    commit = 1'b0;
    tick();
    fv[0] = 1'b1; fl[0] = 1'b1; fv[1] = 1'b1; fl[1] = 1'b1; fv[3] = 1'b1; fl[3] = 1'b1;
    ordy = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1;
      vecs++; if ({selv, sel, ov, ol} !== {1'b1, order[k], 2'b11})
        begin errs++; $display("FAIL rr_pkt%0d got %b want %b", k, {selv, sel, ov, ol}, {1'b1, order[k], 2'b11}); end
      tick();
      vecs++; if ({selv, ov} !== 2'b00) begin errs++; $display("FAIL rr_gap%0d got %b want 00", k, {selv, ov}); end
      tick();
    end
    vecs++; if (selv !== 1'b0) begin errs++; $display("FAIL rr_empty got %b want 0", selv); end
    clear_fifo(); ordy = 1'b0;
  endtask

  task automatic test_backpressure();
    int beats = 0;
    commit = 1'b1; lane = 2'd1;
    tick();
    commit = 1'b0;
    tick();
    vecs++; if ({selv, sel} !== 3'b101) begin errs++; $display("FAIL bp_sel got %b want 101", {selv, sel}); end
    fv[1] = 1'b1;
    for (int c = 0; c < 8; c++) begin
      ordy = (c % 2 == 1);
      fl[1] = (beats == 3);
      #1;
      vecs++; if ({selv, fr[1], fr[0], fr[2], fr[3]} !== {1'b1, ordy, 3'b000})
        begin errs++; $display("FAIL bp_cyc%0d got %b want %b", c, {selv, fr[1], fr[0], fr[2], fr[3]}, {1'b1, ordy, 3'b000}); end
      if (ordy) beats++;
      tick();
    end
    clear_fifo(); ordy = 1'b0;
    vecs++; if (selv !== 1'b0) begin errs++; $display("FAIL bp_done got %b want 0", selv); end
    vecs++; if (dut.count_q[1] !== 5'd0) begin errs++; $display("FAIL bp_cnt got %0d want 0", dut.count_q[1]); end
  endtask

  task automatic test_same_cycle();
    commit = 1'b1; lane = 2'd0;
    tick();
    commit = 1'b0;
    tick();
    vecs++; if ({selv, sel} !== 3'b100) begin errs++; $display("FAIL same_sel got %b want 100", {selv, sel}); end
    fv[0] = 1'b1; fl[0] = 1'b1; ordy = 1'b1; commit = 1'b1; lane = 2'd0;
    tick();
    commit = 1'b0; clear_fifo();
    vecs++; if (dut.count_q[0] !== 5'd1) begin errs++; $display("FAIL same_cnt got %0d want 1", dut.count_q[0]); end
    vecs++; if (selv !== 1'b0) begin errs++; $display("FAIL same_gap got %b want 0", selv); end
    tick();
    vecs++; if ({selv, sel} !== 3'b100) begin errs++; $display("FAIL same_resel got %b want 100", {selv, sel}); end
    fv[0] = 1'b1; fl[0] = 1'b1;
    tick();
    clear_fifo(); ordy = 1'b0;
    vecs++; if (dut.count_q[0] !== 5'd0) begin errs++; $display("FAIL same_drain got %0d want 0", dut.count_q[0]); end
  endtask

  task automatic test_overflow();
    lane = 2'd3;
    for (int i = 0; i < 16; i++) begin
      commit = 1'b1;
      tick();
    end
    commit = 1'b0;
    vecs++; if (ovf !== 1'b0) begin errs++; $display("FAIL ovf_early got %b want 0", ovf); end
    vecs++; if (dut.count_q[3] !== 5'd16) begin errs++; $display("FAIL ovf_cnt16 got %0d want 16", dut.count_q[3]); end
    commit = 1'b1;
    tick();
    commit = 1'b0;
    tick(); tick(); tick();
    vecs++; if ({ovf, dut.count_q[3]} !== {1'b1, 5'd16}) begin errs++; $display("FAIL ovf_sat got %b want 110000", {ovf, dut.count_q[3]}); end
  endtask

  task automatic test_reset_mid();
    vecs++; if ({selv, sel} !== 3'b111) begin errs++; $display("FAIL mid_sel got %b want 111", {selv, sel}); end
    fv[3] = 1'b1; ordy = 1'b1;
    tick();
    #1;
    rst_n = 1'b0;
    #1;
    vecs++; if ({ov, ol, selv, ovf, fr[3]} !== 5'b0) begin errs++; $display("FAIL mid_out got %b want 00000", {ov, ol, selv, ovf, fr[3]}); end
    vecs++; if ({sel, dut.count_q[3]} !== 7'd0) begin errs++; $display("FAIL mid_state got %b want 0", {sel, dut.count_q[3]}); end
    tick();
    rst_n = 1'b1;
    tick(); tick(); tick();
    vecs++; if ({selv, ov, fr[3], ovf} !== 4'b0) begin errs++; $display("FAIL mid_idle got %b want 0000", {selv, ov, fr[3], ovf}); end
    clear_fifo(); ordy = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_same_cycle();
    test_overflow();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
